uart_hex_printer: RTL and testbench
===================================

# uart_hex_printer

Debug status printer for the camera/HDMI/DDR3 top level. It latches a status word on a trigger pulse and serialises it as uppercase ASCII hex, MSB nibble first, terminated by CR LF. The output is 8N1 UART on the board's `uart_tx` pin. It runs in a single clock domain; status sources in other domains are synchronised before they reach `I_data`.

## Interface
Parameters:
- `CLK_FREQ`, 27_000_000: input clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `DATA_W`, 32: status word width; must be a multiple of 4 and at least 4.

Ports:
- `I_clk`, input, 1: the only clock; all logic is on its rising edge.
- `I_rst_n`, input, 1: reset, asynchronous, active-low.
- `I_trig`, input, 1: print request, sampled each cycle.
- `I_data`, input, `DATA_W`: status word; captured only when a trigger is accepted.
- `O_busy`, output, 1: high while a message is in flight.
- `O_done`, output, 1: one-cycle pulse when a message completes.
- `O_uart_tx`, output, 1: serial line; idle level is 1.

## Operation
- Bit period: `CLKS_PER_BIT` = `CLK_FREQ`/`BAUD`, integer truncated (27 MHz / 115200 gives 234). Maintained by a down-counter that reloads each bit.
- Message length: `NCHAR` = `DATA_W`/4 + 2, plus 2 more when the prefix is enabled.
- Character order: optional prefix, then the hex nibbles from MSB to LSB, then 0x0D, then 0x0A.
- Nibble to ASCII: 0–9 map to 0x30–0x39; A–F map to 0x41–0x46.
- Frame format per character: start bit 0, then 8 data bits LSB first, then one stop bit 1. Characters are sent back to back with no idle gap.
- FSM states:
  - IDLE: `O_uart_tx`=1. Leaves on `I_trig`=1, latching `I_data` into a shadow register and clearing the character index.
  - START: lasts 1 bit period.
  - DATA: 8 bit periods; the bit index counts 0 to 7.
  - STOP: 1 bit period. At the end, if the character index is `NCHAR`-1, go to IDLE; otherwise increment the index and go to START.
- Triggers while `O_busy`=1 are ignored and not queued.
- `I_data` changes during a message do not affect the message; only the shadow copy is used.
- A trigger in the same cycle as `O_done` is accepted, because the FSM is already in IDLE that cycle.
- Reset mid-message aborts immediately:
  - `O_uart_tx` goes to 1 asynchronously.
  - The FSM, counters and shadow register clear.
  - No `O_done` is produced.

## Timing
- Reset values: `O_uart_tx`=1, `O_busy`=0, `O_done`=0.
- All outputs are registered.
- Trigger acceptance:
  - `I_trig` high at edge k, while in IDLE, puts the FSM in START from edge k.
  - From edge k, `O_busy`=1 and `O_uart_tx`=0.
- Each bit holds for exactly `CLKS_PER_BIT` cycles.
- Message duration: exactly `NCHAR`×10×`CLKS_PER_BIT` cycles, measured from the start-bit edge to the edge where `O_busy` falls.
- Completion: `O_done`=1 for the single cycle in which `O_busy` first reads 0.
- Back-to-back messages: minimum trigger-to-trigger spacing is message duration + 1 cycle, giving 1 idle cycle of line-high between messages.

## Configuration
- `UART_HEX_PREFIX_EN` defined: every message starts with "0x" (0x30, 0x78), so `NCHAR` = `DATA_W`/4 + 4.
- Undefined: no prefix, so `NCHAR` = `DATA_W`/4 + 2.
- Nothing else differs between the two builds.

## Test plan
Benches use `CLK_FREQ`=1_000_000 and `BAUD`=100_000 (10 clocks per bit) unless stated otherwise.
- Reset: assert `I_rst_n`=0 for 3 cycles, then release. Required: `O_uart_tx`=1, `O_busy`=0, `O_done`=0, with no line activity for 100 cycles.
- Basic print: `I_data`=0xDEADBEEF, `I_trig` pulsed for 1 cycle, prefix off.
  - Decoded bytes: 44 45 41 44 42 45 45 46 0D 0A.
  - `O_busy` high for exactly 1000 cycles; one `O_done` pulse.
- Prefix build: `UART_HEX_PREFIX_EN` defined, `I_data`=0x0000000F.
  - Bytes: 30 78 30 30 30 30 30 30 30 46 0D 0A.
  - `O_busy` high for exactly 1200 cycles.
- Ignored trigger and data change: mid-message, pulse `I_trig` and change `I_data` to 0x12345678. Required: the original message is unchanged and no second message follows.
- Back-to-back: hold `I_trig`=1 continuously with `I_data`=0x00000001. Required: consecutive messages separated by exactly 1 line-high cycle, each decoding "00000001\r\n".
- Abort: assert reset during the 5th character's DATA state. Required: `O_uart_tx`=1 within the same cycle, no `O_done`, and a clean full message on the next trigger after release.
- Default parameters: at 27 MHz and 115200 baud, the measured bit period is 234 cycles.

Source files
------------

// File: rtl/uart_hex_printer.sv
// Debug status printer: latches a word on a trigger and sends it as uppercase ASCII hex + CR LF
// over 8N1 UART. Define UART_HEX_PREFIX_EN to prepend "0x" to every message.
module uart_hex_printer #(
  parameter int unsigned CLK_FREQ = 27_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_trig,
  input  logic [DATA_W-1:0] I_data,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_uart_tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
`ifdef UART_HEX_PREFIX_EN
  localparam int unsigned PREFIX_N = 2;
`else
  localparam int unsigned PREFIX_N = 0;
`endif
  localparam int unsigned NCHAR  = DATA_W / 4 + 2 + PREFIX_N;
  localparam int unsigned CHAR_W = $clog2(NCHAR);
  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]  CntReload = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CHAR_W-1:0] LastChar  = CHAR_W'(NCHAR - 1);
  localparam logic [CHAR_W-1:0] CrChar    = CHAR_W'(NCHAR - 2);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [CHAR_W-1:0]   char_q, char_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [CHAR_W-1:0]   nib_idx;
  logic [DATA_W-1:0]   shifted;
  logic [3:0]          nibble;
  logic [7:0]          cur_byte;

  // Byte for the current character index; nibble 0 is the MSB nibble of the shadow word.
  always_comb begin
    nib_idx  = char_q - CHAR_W'(PREFIX_N);
    shifted  = shadow_q << {nib_idx, 2'b00};
    nibble   = shifted[DATA_W-1 -: 4];
    cur_byte = (nibble < 4'd10) ? {4'h3, nibble} : (8'h37 + {4'h0, nibble});
    if (char_q == LastChar) begin
      cur_byte = 8'h0A;
    end else if (char_q == CrChar) begin
      cur_byte = 8'h0D;
`ifdef UART_HEX_PREFIX_EN
    end else if (char_q == '0) begin
      cur_byte = 8'h30;
    end else if (char_q == CHAR_W'(1)) begin
      cur_byte = 8'h78;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    char_d   = char_q;
    shadow_d = shadow_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (I_trig) begin
          state_d  = StStart;
          shadow_d = I_data;
          char_d   = '0;
          cnt_d    = CntReload;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          state_d = StData;
          cnt_d   = CntReload;
          bit_d   = '0;
          tx_d    = cur_byte[0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          cnt_d = CntReload;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          if (char_q == LastChar) begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StStart;
            char_d  = char_q + CHAR_W'(1);
            cnt_d   = CntReload;
            tx_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      char_q   <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      char_q   <= char_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign O_uart_tx = tx_q;
  assign O_busy    = busy_q;
  assign O_done    = done_q;

endmodule

// File: tb/tb_uart_hex_printer.sv
// Bench for uart_hex_printer: cycle-level line model, independent UART receiver, literal checks.
`timescale 1ns/1ps
module tb_uart_hex_printer;

  localparam int unsigned C = 10;
`ifdef UART_HEX_PREFIX_EN
  localparam int unsigned NCHAR = 12;
  localparam int unsigned MSG_LIT = 1200;
`else
  localparam int unsigned NCHAR = 10;
  localparam int unsigned MSG_LIT = 1000;
`endif
  localparam int unsigned MSG_CYC = NCHAR * 10 * C;
  localparam int unsigned DEF_C = 234;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig = 1'b0;
  logic [31:0] data = '0;
  logic busy, done, tx;
  logic def_trig = 1'b0;
  logic [31:0] def_data = '0;
  logic def_busy, def_done, def_tx;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  uart_hex_printer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(32)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_trig(trig), .I_data(data),
    .O_busy(busy), .O_done(done), .O_uart_tx(tx)
  );

  uart_hex_printer dut_def (
    .I_clk(clk), .I_rst_n(rst_n), .I_trig(def_trig), .I_data(def_data),
    .O_busy(def_busy), .O_done(def_done), .O_uart_tx(def_tx)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Message text by rule: optional "0x", 8 uppercase hex digits MSB first, CR, LF.
  function automatic byte msg_byte(input logic [31:0] d, input int unsigned i);
    string hex;
    int unsigned k;
    int unsigned nib;
    hex = "0123456789ABCDEF";
    k = i;
`ifdef UART_HEX_PREFIX_EN
    if (k == 0) return 8'h30;
    if (k == 1) return 8'h78;
    k = k - 2;
`endif
    if (k < 8) begin
      nib = int'((d >> (28 - 4 * k)) & 32'hF);
      return hex[nib];
    end
    if (k == 8) return 8'h0D;
    return 8'h0A;
  endfunction

  // Reference model: line level as a function of time since the start-bit edge.
  logic [31:0] m_shadow = '0;
  int unsigned m_t = 0;
  bit m_busy = 1'b0, m_done = 1'b0, m_tx = 1'b1;

  function automatic logic line_bit(input int unsigned t);
    byte b;
    int unsigned pos;
    b = msg_byte(m_shadow, t / (10 * C));
    pos = (t / C) % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_tx <= 1'b1; m_t <= 0;
    end else if (m_busy) begin
      if (m_t + 1 == MSG_CYC) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_tx <= 1'b1;
      end else begin
        m_t <= m_t + 1; m_done <= 1'b0; m_tx <= line_bit(m_t + 1);
      end
    end else if (trig) begin
      m_busy <= 1'b1; m_t <= 0; m_shadow <= data; m_tx <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_tx", tx, m_tx);
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
    end
    if (done === 1'b1) done_cnt++;
  end

  // Independent receiver sampling mid-bit.
  byte rx_q[$];
  initial begin
    byte b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        repeat (C / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx;
        end
        repeat (C) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < int'(MSG_CYC) + 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic print_msg(input logic [31:0] d, output int unsigned bc);
    bc = 0;
    rx_q.delete();
    @(negedge clk); data = d; trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    for (int i = 0; i < int'(MSG_CYC) + 50; i++) begin
      if (busy === 1'b1) bc++;
      if (done === 1'b1) break;
      @(negedge clk);
    end
    check("print_done_seen", done, 1'b1);
  endtask

  task automatic check_bytes(input string name, input logic [31:0] d);
    check({name, "_len"}, rx_q.size(), NCHAR);
    for (int i = 0; i < int'(NCHAR) && i < rx_q.size(); i++)
      check({name, "_byte"}, rx_q[i], msg_byte(d, i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bc;
    int gap, cnt, dn0;
    byte exp_b[$];
    logic [31:0] d0;

    // Reset
    @(posedge clk); @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) cnt++;
    end
    check("rst_quiet", cnt, 0);

    // Basic print against hand-computed bytes
`ifdef UART_HEX_PREFIX_EN
    d0 = 32'h0000_000F;
    exp_b = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h46,
              8'h0D, 8'h0A};
`else
    d0 = 32'hDEAD_BEEF;
    exp_b = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
`endif
    dn0 = done_cnt;
    print_msg(d0, bc);
    repeat (2) @(negedge clk);
    check("basic_busy_len", bc, MSG_LIT);
    check("basic_done_pulses", done_cnt - dn0, 1);
    check("basic_len", rx_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++)
      check("basic_byte", rx_q[i], exp_b[i]);

    // Trigger and data change mid-message are ignored
    rx_q.delete();
    d0 = $urandom;
    @(negedge clk); data = d0; trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    repeat (400) @(negedge clk);
    trig = 1'b1; data = 32'h1234_5678;
    @(negedge clk); trig = 1'b0;
    wait_done();
    check_bytes("ignore", d0);
    cnt = 0;
    repeat (1500) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
    end
    check("ignore_no_second", cnt, 0);

    // Random triggers and data; the per-cycle model does the checking
    repeat (6000) begin
      @(negedge clk);
      trig = ($urandom_range(0, 99) < 2);
      data = $urandom;
    end
    trig = 1'b0;
    for (int i = 0; i < int'(MSG_CYC) + 10 && busy === 1'b1; i++) @(negedge clk);
    check("random_idle", busy, 1'b0);
    repeat (20) @(negedge clk);

    // Back-to-back with trigger held
    rx_q.delete();
    @(negedge clk); data = 32'h0000_0001; trig = 1'b1;
    for (int m = 0; m < 3; m++) begin
      wait_done();
      if (m == 2) begin
        trig = 1'b0;
      end else begin
        gap = 1;
        @(negedge clk);
        while (busy !== 1'b1 && gap < 20) begin
          gap++;
          @(negedge clk);
        end
        check("b2b_gap", gap, 1);
      end
    end
    check("b2b_count", rx_q.size(), 3 * NCHAR);
    for (int i = 0; i < rx_q.size(); i++)
      check("b2b_byte", rx_q[i], msg_byte(32'h1, i % NCHAR));
    check("b2b_last_digit", rx_q[NCHAR-3], 8'h31);
    check("b2b_lf", rx_q[NCHAR-1], 8'h0A);
    repeat (20) @(negedge clk);

    // Abort during DATA of the 5th character
    @(negedge clk); data = 32'hCAFE_1234; trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    repeat (450) @(negedge clk);
    dn0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("abort_no_done", done_cnt - dn0, 0);
    print_msg(32'h0BAD_F00D, bc);
    check("abort_after_len", bc, MSG_CYC);
    check_bytes("abort_after", 32'h0BAD_F00D);
    repeat (5) @(negedge clk);

    // Default parameters: 234 clocks per bit
    bc = 0;
    @(negedge clk); def_data = 32'h1000_0000; def_trig = 1'b1;
    @(negedge clk); def_trig = 1'b0;
    for (int i = 0; i < int'(NCHAR * 10 * DEF_C) + 100; i++) begin
      if (def_busy === 1'b1) bc++;
      if (def_done === 1'b1) break;
      @(negedge clk);
    end
    check("def_done_seen", def_done, 1'b1);
    check("def_busy_len", bc, NCHAR * 10 * DEF_C);
    check("def_idle_tx", def_tx, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
